// File: rtl/fifo_2w_1r_if.sv
// Handshake bundle for fifo_2w_1r: pair write port, single read port.
// FIFO_2W1R_SINGLE_WRITE_EN adds WriteEn_in_1 (push Data_in_1 only).
interface fifo_2w_1r_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] Data_in_1;
  logic [DATA_WIDTH-1:0] Data_in_2;
  logic                  WriteEn_in_2;
`ifdef FIFO_2W1R_SINGLE_WRITE_EN
  logic                  WriteEn_in_1;
`endif
  logic                  Full_out;
  logic                  ReadEn_in;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  Data_valid;
  logic                  Empty_out;

  modport master (
    output Data_in_1,
    output Data_in_2,
    output WriteEn_in_2,
`ifdef FIFO_2W1R_SINGLE_WRITE_EN
    output WriteEn_in_1,
`endif
    output ReadEn_in,
    input  Full_out,
    input  Data_out,
    input  Data_valid,
    input  Empty_out
  );

  modport slave (
    input  Data_in_1,
    input  Data_in_2,
    input  WriteEn_in_2,
`ifdef FIFO_2W1R_SINGLE_WRITE_EN
    input  WriteEn_in_1,
`endif
    input  ReadEn_in,
    output Full_out,
    output Data_out,
    output Data_valid,
    output Empty_out
  );
endinterface

// File: rtl/fifo_2w_1r.sv
// Sync FIFO: pushes a word pair per write, pops one word per read.
// FIFO_2W1R_SINGLE_WRITE_EN enables the single-word write enable.
module fifo_2w_1r #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input logic          Clk,
  input logic          Clear_n,
  fifo_2w_1r_if.slave  bus
);
  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wptr;
  logic [ADDRESS_WIDTH-1:0] wptr1;
  logic [ADDRESS_WIDTH-1:0] rptr;
  logic [CW-1:0]            count;
  logic [CW-1:0]            cnt_nxt;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic                     wr2;
  logic                     wr1;
  logic                     rd;

  assign bus.Empty_out  = (count == '0);
  assign bus.Full_out   = (count > CW'(FIFO_DEPTH - 2));
  assign bus.Data_out   = rd_data;
  assign bus.Data_valid = rd_valid;

  assign wr2   = bus.WriteEn_in_2 && !bus.Full_out;
  assign rd    = bus.ReadEn_in && !bus.Empty_out;
  assign wptr1 = wptr + 1'b1;

`ifdef FIFO_2W1R_SINGLE_WRITE_EN
  // Single write may use the last free slot that pair writes cannot.
  assign wr1 = bus.WriteEn_in_1 && !bus.WriteEn_in_2
            && (count < CW'(FIFO_DEPTH));
`else
  assign wr1 = 1'b0;
`endif

  always_comb begin
    cnt_nxt = count;
    if (wr2)
      cnt_nxt = cnt_nxt + CW'(2);
    else if (wr1)
      cnt_nxt = cnt_nxt + CW'(1);
    if (rd)
      cnt_nxt = cnt_nxt - CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (wr2) begin
      mem[wptr]  <= bus.Data_in_1;
      mem[wptr1] <= bus.Data_in_2;
    end else if (wr1) begin
      mem[wptr]  <= bus.Data_in_1;
    end
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      count    <= cnt_nxt;
      rd_valid <= rd;
      if (wr2)
        wptr <= wptr + ADDRESS_WIDTH'(2);
      else if (wr1)
        wptr <= wptr1;
      if (rd) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_2w_1r.sv
// Scoreboard bench for fifo_2w_1r: directed pair/read vectors,
// queue model predicts pops, negedge monitor compares outputs.
module tb_fifo_2w_1r;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0] store [$];
  logic [7:0] exp_q [$];
  logic [7:0] last = 8'h00;
  int         m_n;
  logic       m_rd;

  always #5 clk = ~clk;

  fifo_2w_1r_if #(.DATA_WIDTH(8)) bus ();

  fifo_2w_1r #(
    .DATA_WIDTH(8),
    .ADDRESS_WIDTH(4)
  ) dut (
    .Clk(clk),
    .Clear_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, required %0h @%0t",
               nm, act, exp, $time);
  endtask

  // Reference model: a read sees only words stored on earlier edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store.delete();
      exp_q.delete();
      last = 8'h00;
    end else begin
      m_n  = store.size();
      m_rd = bus.ReadEn_in && (m_n > 0);
      if (m_rd)
        exp_q.push_back(store.pop_front());
      if (bus.WriteEn_in_2 && m_n < 15) begin
        store.push_back(bus.Data_in_1);
        store.push_back(bus.Data_in_2);
      end
`ifdef FIFO_2W1R_SINGLE_WRITE_EN
      else if (bus.WriteEn_in_1 && m_n < 16)
        store.push_back(bus.Data_in_1);
`endif
    end
  end

  always @(negedge clk) begin
    check("empty", 32'(bus.Empty_out), 32'(store.size() == 0));
    check("full", 32'(bus.Full_out), 32'(store.size() > 14));
    check("valid", 32'(bus.Data_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0)
      last = exp_q.pop_front();
    check("data", 32'(bus.Data_out), 32'(last));
  end

  task automatic cyc(input logic w, input logic [7:0] a,
                     input logic [7:0] b, input logic r);
    bus.WriteEn_in_2 = w;
    bus.Data_in_1    = a;
    bus.Data_in_2    = b;
    bus.ReadEn_in    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] v;
`ifdef FIFO_2W1R_SINGLE_WRITE_EN
    bus.WriteEn_in_1 = 1'b0;
`endif
    // reset held with random stimulus
    for (int i = 0; i < 4; i++)
      cyc(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    check("rst_empty", 32'(bus.Empty_out), 32'd1);
    check("rst_full", 32'(bus.Full_out), 32'd0);
    check("rst_valid", 32'(bus.Data_valid), 32'd0);
    check("rst_data", 32'(bus.Data_out), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // pair order with continuous read
    cyc(1'b1, 8'd1, 8'd2, 1'b1);
    cyc(1'b1, 8'd3, 8'd4, 1'b1);
    drain(4);
    idle(3);
    check("hold4", 32'(bus.Data_out), 32'd4);

    // fill and overflow
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 8'(2*i+1), 8'(2*i+2), 1'b0);
    check("fill_full", 32'(bus.Full_out), 32'd1);
    drain(18);
    idle(2);
    check("drain_empty", 32'(bus.Empty_out), 32'd1);

    // full threshold at 15/14
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 8'(8'h40+2*i), 8'(8'h41+2*i), 1'b0);
    drain(1);
    check("c15_full", 32'(bus.Full_out), 32'd1);
    cyc(1'b1, 8'hE0, 8'hE1, 1'b0);
    drain(1);
    check("c14_full", 32'(bus.Full_out), 32'd0);
    cyc(1'b1, 8'hA0, 8'hA1, 1'b0);
    check("c16_full", 32'(bus.Full_out), 32'd1);
    drain(18);
    idle(2);

    // sustained traffic across several wraps
    v = 8'd0;
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1, v, v + 8'd1, 1'b1);
      v = v + 8'd2;
    end
    drain(20);
    idle(2);

    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'(8'h70+2*i), 8'(8'h71+2*i), 1'b0);
    cyc(1'b1, 8'h90, 8'h91, 1'b1);
    cyc(1'b1, 8'h92, 8'h93, 1'b1);
    bus.WriteEn_in_2 = 1'b0;
    bus.ReadEn_in    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(bus.Empty_out), 32'd1);
    check("arst_valid", 32'(bus.Data_valid), 32'd0);
    check("arst_data", 32'(bus.Data_out), 32'd0);
    check("arst_full", 32'(bus.Full_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    cyc(1'b1, 8'd7, 8'd8, 1'b0);
    drain(3);
    idle(2);
    check("post_data", 32'(bus.Data_out), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_2w_1r.md
Name: fifo_2w_1r

Overview:
Synchronous FIFO with a dual-word write port and a single-word read port. Each accepted write pushes two words (Data_in_1 first, then Data_in_2). Each accepted read pops one word. It sits between a producer that emits word pairs and a consumer that drains one word per cycle. Both ports run on one clock.

Parameters:
DATA_WIDTH, 8, width of each stored word.
ADDRESS_WIDTH, 4, storage address width; minimum value 2.
FIFO_DEPTH, 1<<ADDRESS_WIDTH, number of word entries. Derived; do not override.

Ports:
Clk  input  1  single clock; all state changes on the rising edge.
Clear_n  input  1  asynchronous active-low reset.
Data_in_1  input  DATA_WIDTH  first word of the write pair (older).
Data_in_2  input  DATA_WIDTH  second word of the write pair (younger).
WriteEn_in_2  input  1  request to push both Data_in_1 and Data_in_2.
Full_out  output  1  fewer than 2 free entries; a pair write would be dropped.
ReadEn_in  input  1  request to pop one word.
Data_out  output  DATA_WIDTH  registered read data.
Data_valid  output  1  one-cycle strobe; Data_out holds a newly popped word.
Empty_out  output  1  no stored words.

Behaviour:
- State: storage array [FIFO_DEPTH] x DATA_WIDTH; write pointer and read pointer (ADDRESS_WIDTH bits, wrap modulo FIFO_DEPTH); count (ADDRESS_WIDTH+1 bits, range 0..FIFO_DEPTH).
- Reset (Clear_n=0, async, takes effect immediately at any time, including mid-operation):
  - pointers=0, count=0, Data_out=0, Data_valid=0;
  - Empty_out=1, Full_out=0;
  - storage contents need not be cleared.
- Flags are combinational from the registered count:
  - Empty_out = (count==0);
  - Full_out = (count > FIFO_DEPTH-2).
- Write accept: wr_ok = WriteEn_in_2 && !Full_out.
  - On accept: mem[wptr]=Data_in_1, mem[wptr+1]=Data_in_2 (wrapping), wptr+=2.
  - When Full_out=1 the request is silently dropped. No partial writes; no error flag.
- Read accept: rd_ok = ReadEn_in && !Empty_out.
  - On accept: Data_out <= mem[rptr] at the same edge, rptr+=1, Data_valid <= 1.
  - Otherwise Data_valid <= 0 and Data_out holds its last value.
  - Read latency: one cycle from the accepting edge; throughput one word per cycle.
- Simultaneous accepted read and write: count += 1.
- A read accepted in a given cycle sees only data written on earlier edges. No write-to-read bypass: a word written at edge N is readable at the earliest from edge N+1.
- Count update: +2 (write only), -1 (read only), +1 (both), 0 (neither).
- ReadEn_in while empty and WriteEn_in_2 while full are legal no-ops.
- Ordering is strict FIFO across pointer wrap-around. No word is lost, duplicated or reordered.

Optional Feature:
Macro FIFO_2W1R_SINGLE_WRITE_EN.
- Defined:
  - adds input WriteEn_in_1 (1 bit), which pushes only Data_in_1;
  - accepted when WriteEn_in_1 && !WriteEn_in_2 && count < FIFO_DEPTH;
  - pointer +1, count +1 (net 0 with a simultaneous read);
  - when both enables are high, WriteEn_in_2 takes precedence and the pair write rules apply;
  - Full_out definition is unchanged (pair-room), so a single write can still land while Full_out=1 and count==FIFO_DEPTH-1.
- Undefined: the port does not exist and only pair writes are possible.

Test Plan:
(DATA_WIDTH=8, ADDRESS_WIDTH=4, depth 16.)
1. Reset: hold Clear_n=0 with random inputs -> Empty_out=1, Full_out=0, Data_valid=0, Data_out=0. Assert Clear_n=0 asynchronously between edges -> outputs reset before the next edge.
2. Pair order: ReadEn_in=1; write (1,2) then (3,4) on consecutive edges -> Data_valid high with Data_out 1,2,3,4 on four consecutive cycles. Empty_out=1 after the last pop; Data_valid=0 afterwards with Data_out holding 4.
3. Fill/overflow: ReadEn_in=0; write pairs (1,2)…(15,16) -> Full_out=1 after the 8th pair (count 16). 9th pair (17,18) is dropped. Drain reads 1..16 exactly, then Empty_out=1.
4. Full threshold: count 15 -> Full_out=1 and a pair write is dropped. After one read (count 14) -> Full_out=0 and the next pair is accepted (count 16).
5. Sustained traffic: WriteEn_in_2=1 and ReadEn_in=1 every cycle with an incrementing pair stream -> count rises by 1 per cycle until Full_out gates writes. Reads continue one word per cycle. The output stream is contiguous and in order across more than 3 pointer wraps.
6. Mid-stream reset: pulse Clear_n low with 10 words stored -> FIFO empty, no Data_valid. A subsequent pair (7,8) reads back as 7 then 8.
